// File: rtl/ht_core_if.sv
// Sample-vector port bundle for the Walsh-Hadamard engine: level start request,
// parallel input block, parallel result block and the result-valid flag.
interface ht_core_if #(
    parameter int index = 8,
    parameter int width = 4
);
    logic             start;
    logic [width-1:0] indata  [0:index-1];
    logic [width-1:0] outdata [0:index-1];
    logic             over;

    modport master (
        output start,
        output indata,
        input  outdata,
        input  over
    );

    modport slave (
        input  start,
        input  indata,
        output outdata,
        output over
    );
endinterface

// File: rtl/ht_core.sv
// Iterative in-place Walsh-Hadamard transform over `index` samples, one butterfly stage per clock.
// Latency: start sampled at edge 0, stages on edges 1..index_width, over high after edge index_width.
// No backpressure: result is held (over=1) while start stays high; start low returns to IDLE.
module ht_core #(
    parameter int index       = 8,
    parameter int width       = 4,
    parameter int index_width = $clog2(index)
) (
    input  logic     clk,
    input  logic     rst_n,
    ht_core_if.slave io
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [index_width-1:0] LAST_STAGE = index_width'(index_width - 1);

    state_t                 state_q, state_d;
    logic [index_width-1:0] stage_q, stage_d;
    logic [width-1:0]       x_q [index];
    logic [width-1:0]       x_d [index];

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    for (int i = 0; i < index; i++) begin
                        x_d[i] = io.indata[i];
                    end
                    stage_d = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // Stage s pairs element i with i+2^s for every i whose bit s is clear;
                // sums and differences wrap naturally at the word width.
                for (int s = 0; s < index_width; s++) begin
                    if (int'(stage_q) == s) begin
                        for (int i = 0; i < index; i++) begin
                            if (((i >> s) & 1) == 0) begin
                                x_d[i]            = x_q[i] + x_q[i + (1 << s)];
                                x_d[i + (1 << s)] = x_q[i] - x_q[i + (1 << s)];
                            end
                        end
                    end
                end
                if (stage_q == LAST_STAGE) begin
                    stage_d = '0;
                    state_d = DONE;
                end else begin
                    stage_d = stage_q + 1'b1;
                end
            end
            DONE: begin
                if (!io.start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            stage_q <= '0;
            for (int i = 0; i < index; i++) begin
                x_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            x_q     <= x_d;
        end
    end

    always_comb begin
        for (int i = 0; i < index; i++) begin
            io.outdata[i] = x_q[i];
        end
    end

    assign io.over = (state_q == DONE);

endmodule

// File: tb/tb_ht_core.sv
// Randomised and directed bench for ht_core; expected results come from a direct
// sum-of-signs Hadamard model and are checked by a monitor when over rises.
module tb_ht_core;
    localparam int IDX = 8;
    localparam int W   = 4;
    localparam int STG = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ht_core_if #(.index(IDX), .width(W)) ifc ();

    ht_core #(.index(IDX), .width(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (ifc)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] exp;
        int          c0;
        string       name;
    } exp_t;

    exp_t sbq[$];

    // y[k] = sum_i x[i] * (-1)^popcount(i&k), reduced mod 2^W
    function automatic logic [31:0] wht_model(input logic [31:0] v);
        logic [31:0] r;
        int acc;
        r = '0;
        for (int k = 0; k < IDX; k++) begin
            acc = 0;
            for (int i = 0; i < IDX; i++) begin
                if (($countones(i & k) % 2) == 1) acc -= int'(v[i*W +: W]);
                else                              acc += int'(v[i*W +: W]);
            end
            r[k*W +: W] = acc[W-1:0];
        end
        return r;
    endfunction

    function automatic logic [31:0] get_out();
        logic [31:0] p;
        for (int i = 0; i < IDX; i++) p[i*W +: W] = ifc.outdata[i];
        return p;
    endfunction

    task automatic drive(input logic [31:0] v);
        for (int i = 0; i < IDX; i++) ifc.indata[i] = v[i*W +: W];
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    // Monitor: every rising edge of over must match the oldest outstanding run.
    logic over_prev = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ifc.over === 1'b1 && over_prev !== 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_over", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check({e.name, "_data"}, get_out(), e.exp);
                check({e.name, "_latency"}, 32'(cyc - e.c0), 32'(STG));
            end
        end
        over_prev = ifc.over;
    end

    task automatic do_run(input string nm, input logic [31:0] v,
                          input logic [31:0] exp, input bit hold);
        exp_t e;
        int   n;
        @(negedge clk);
        drive(v);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        e.exp  = exp;
        e.c0   = cyc;
        e.name = nm;
        sbq.push_back(e);
        drive($urandom());
        if (!hold) ifc.start = 1'b0;
        n = 0;
        while (ifc.over !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (ifc.over !== 1'b1) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            void'(sbq.pop_front());
        end
        if (hold) begin
            repeat (4) @(negedge clk);
            check({nm, "_hold_over"}, 32'(ifc.over), 32'd1);
            check({nm, "_hold_stable"}, get_out(), exp);
            ifc.start = 1'b0;
            @(negedge clk);
            check({nm, "_hold_drop"}, 32'(ifc.over), 32'd0);
        end else begin
            @(negedge clk);
            check({nm, "_drop"}, 32'(ifc.over), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] v;
        rst_n     = 1'b0;
        ifc.start = 1'b0;
        drive(32'h0);
        #12;
        check("reset_over", 32'(ifc.over), 32'd0);
        check("reset_out", get_out(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_run("zero",    32'h0000_0000, 32'h0000_0000, 1'b0);
        do_run("impulse", 32'h0000_0001, 32'h1111_1111, 1'b0);
        do_run("ones",    32'h1111_1111, 32'h0000_0008, 1'b0);
        do_run("ramp",    32'h8765_4321, 32'h0000_08C4, 1'b0);

        v = $urandom();
        do_run("held", v, wht_model(v), 1'b1);

        // Abort during the second butterfly stage.
        @(negedge clk);
        drive(32'h8765_4321);
        ifc.start = 1'b1;
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
        @(negedge clk);
        check("loaded_vector", get_out(), 32'h8765_4321);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_over", 32'(ifc.over), 32'd0);
        check("abort_out", get_out(), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_run("after_abort", 32'h8765_4321, 32'h0000_08C4, 1'b0);

        for (int r = 0; r < 10; r++) begin
            v = $urandom();
            do_run($sformatf("rand%0d", r), v, wht_model(v), bit'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
